alu_operand_loader: RTL and testbench
=====================================

// Module: alu_operand_loader
// PURPOSE
//  Input-side front end for the ALU demo board, complementing the display path. Replaces
//  per-register button clocks with one system clock: a raw push button is synchronised,
//  debounced and edge-detected, and a 4-state FSM steps through operand A, operand B, opcode
//  and execute. All captures come from the switch bank. Outputs feed the ALU operand/op
//  inputs and the result/flag register enable.
// PARAMETERS
//  DW               32      operand width (A, B, switch bank)
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles before debounced level changes (>=1)
// PORTS
//  clk         in   1    system clock, all logic on rising edge
//  rst_n       in   1    synchronous, active-low reset
//  btn         in   1    raw push button, asynchronous, bouncy, active-high
//  sw          in   DW   switch bank, sampled directly (treated as quasi-static)
//  a_out       out  DW   captured operand A
//  b_out       out  DW   captured operand B
//  op_out      out  4    captured opcode (sw[3:0])
//  exec_pulse  out  1    one-cycle strobe: latch ALU result and flags
//  state_out   out  2    FSM state: 0 LOAD_A, 1 LOAD_B, 2 LOAD_OP, 3 SHOW
// BEHAVIOUR
//  Reset (rst_n=0 at a clock edge): sync1, sync2, db, db_d, press, cnt, a_out, b_out, op_out,
//   exec_pulse all 0; state = LOAD_A. Reset mid-sequence discards partial loads.
//  Synchroniser: sync1<=btn; sync2<=sync1.
//  Debounce: if sync2==db then cnt<=0. Else if cnt==DEBOUNCE_CYCLES-1 then db<=sync2, cnt<=0;
//   else cnt<=cnt+1. Counter width $clog2(DEBOUNCE_CYCLES)+1, never wraps.
//   Bounce shorter than DEBOUNCE_CYCLES cycles never changes db.
//  Edge detect: db_d<=db; press<=db & ~db_d (registered, exactly 1 cycle per 0->1 of db).
//   db falling (button release) produces no pulse.
//  Latency: btn first sampled high at edge E0 and held -> db=1 after edge E0+N+1,
//   press=1 after edge E0+N+2, FSM acts at edge E0+N+3 (N=DEBOUNCE_CYCLES).
//  FSM (advances only on press=1; otherwise holds state and all registers):
//   LOAD_A : a_out<=sw; ->LOAD_B
//   LOAD_B : b_out<=sw; ->LOAD_OP
//   LOAD_OP: op_out<=sw[3:0]; exec_pulse<=1; ->SHOW
//   SHOW   : no capture; ->LOAD_A (previous a_out/b_out/op_out held until overwritten)
//  exec_pulse: 1 only in the cycle after LOAD_OP->SHOW transition edge; 0 otherwise.
//   ALU sees new op_out in same cycle exec_pulse is high; consumer latches on that cycle's
//   end only if its path is combinational from op_out (ALU is).
//  Held button: one press only, no auto-repeat, regardless of hold length.
//  Button held across reset release: sync chain restarts from 0, so exactly one press
//   occurs N+3 edges after first sampled-high edge post-reset; FSM in LOAD_A captures A.
//  sw changes at any time; only value present at the capture edge matters.
// TESTING (benches use DEBOUNCE_CYCLES=4)
//  Clean press: rst, sw=0x0000_0012, btn 0->1 held 20 cycles -> a_out=0x12 exactly 7
//   edges after first high sample; state_out 0->1; b_out, op_out still 0.
//  Bounce: btn toggles every 2 cycles for 12 cycles then stays 1 -> exactly one press,
//   one state advance; 3-cycle high glitch alone -> no change.
//  Full sequence: sw=5 press, sw=3 press, sw=0x1 press -> a_out=5, b_out=3, op_out=1,
//   exec_pulse high exactly 1 cycle, state_out=3; 4th press -> state_out=0, regs held.
//  Hold/release: btn held 100 cycles then released 100 cycles -> one advance only.
//  Reset mid-op: after A,B loaded, rst_n=0 one edge -> all outputs 0, state LOAD_A; btn held
//   through reset release -> a_out=sw 7 edges after release.
//  Wrap: 8 presses -> two exec_pulses, state_out returns to 0, latest captures held.

Source files
------------

// File: rtl/alu_operand_loader_if.sv
// Bus between the ALU demo board front panel (button, switch bank) and the operand loader.
// The loader drives the operand/opcode/strobe/state side, the board drives button and switches.
interface alu_operand_loader_if #(
    parameter int unsigned DW = 32
);
    logic          btn;
    logic [DW-1:0] sw;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic [3:0]    op_out;
    logic          exec_pulse;
    logic [1:0]    state_out;

    modport master (
        output btn,
        output sw,
        input  a_out,
        input  b_out,
        input  op_out,
        input  exec_pulse,
        input  state_out
    );

    modport slave (
        input  btn,
        input  sw,
        output a_out,
        output b_out,
        output op_out,
        output exec_pulse,
        output state_out
    );
endinterface

// File: rtl/alu_operand_loader.sv
// ALU demo board input front end: synchronise, debounce and edge-detect one push button,
// then step operand A, operand B and opcode captures from the switch bank, then show.
module alu_operand_loader #(
    parameter int unsigned DW              = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_operand_loader_if.slave bus
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [1:0] LOAD_A  = 2'd0;
    localparam logic [1:0] LOAD_B  = 2'd1;
    localparam logic [1:0] LOAD_OP = 2'd2;
    localparam logic [1:0] SHOW    = 2'd3;

    logic          sync1;
    logic          sync2;
    logic          db;
    logic          db_d;
    logic          press;
    logic [CW-1:0] cnt;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [DW-1:0] a_q;
    logic [DW-1:0] a_d;
    logic [DW-1:0] b_q;
    logic [DW-1:0] b_d;
    logic [3:0]    op_q;
    logic [3:0]    op_d;
    logic          exec_q;
    logic          exec_d;

    // Two-flop synchroniser, debounce counter and rising-edge detector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            db_d  <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= bus.btn;
            sync2 <= sync1;
            db_d  <= db;
            press <= db & ~db_d;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // FSM and capture registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            exec_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            exec_q  <= exec_d;
        end
    end

    // Next state and next captures; everything holds unless a debounced press arrives.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        exec_d  = 1'b0;
        if (press) begin
            case (state_q)
                LOAD_A: begin
                    a_d     = bus.sw;
                    state_d = LOAD_B;
                end
                LOAD_B: begin
                    b_d     = bus.sw;
                    state_d = LOAD_OP;
                end
                LOAD_OP: begin
                    op_d    = bus.sw[3:0];
                    exec_d  = 1'b1;
                    state_d = SHOW;
                end
                SHOW: begin
                    state_d = LOAD_A;
                end
            endcase
        end
    end

    assign bus.a_out      = a_q;
    assign bus.b_out      = b_q;
    assign bus.op_out     = op_q;
    assign bus.exec_pulse = exec_q;
    assign bus.state_out  = state_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short debounce window (4 cycles).
module tb_alu_operand_loader;
    localparam int unsigned DW = 32;
    localparam int unsigned N  = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   pulses;
    int   total_pulses;

    alu_operand_loader_if #(.DW(DW)) bus ();

    alu_operand_loader #(.DW(DW), .DEBOUNCE_CYCLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance k rising edges; inputs change and outputs are sampled 1 ns after each edge.
    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Clean press: 20 cycles high, 20 low, counting exec pulses seen on the way.
    task automatic press(input logic [31:0] v, output int p);
        p = 0;
        bus.sw  = v;
        bus.btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.exec_pulse) p++;
        end
        bus.btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.exec_pulse) p++;
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        bus.btn = 1'b0;
        bus.sw  = '0;
        tick(3);
        chk("rst_a", bus.a_out, 32'h0);
        chk("rst_b", bus.b_out, 32'h0);
        chk("rst_op", 32'(bus.op_out), 32'h0);
        chk("rst_exec", 32'(bus.exec_pulse), 32'h0);
        chk("rst_state", 32'(bus.state_out), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Clean press: capture lands exactly 7 edges after the first high sample.
        bus.sw  = 32'h0000_0012;
        bus.btn = 1'b1;
        tick(7);
        chk("clean_a_early", bus.a_out, 32'h0);
        chk("clean_state_early", 32'(bus.state_out), 32'h0);
        tick(1);
        chk("clean_a", bus.a_out, 32'h12);
        chk("clean_state", 32'(bus.state_out), 32'h1);
        chk("clean_b", bus.b_out, 32'h0);
        chk("clean_op", 32'(bus.op_out), 32'h0);
        tick(12);
        bus.btn = 1'b0;
        tick(20);
        chk("clean_release_state", 32'(bus.state_out), 32'h1);

        // 3-cycle glitch is shorter than the debounce window.
        bus.sw  = 32'h0000_0077;
        bus.btn = 1'b1;
        tick(3);
        bus.btn = 1'b0;
        tick(20);
        chk("glitch_state", 32'(bus.state_out), 32'h1);
        chk("glitch_b", bus.b_out, 32'h0);

        // Bouncy press: toggle every 2 cycles for 12 cycles, then settle high.
        bus.sw = 32'h0000_0003;
        for (int i = 0; i < 6; i++) begin
            bus.btn = ~bus.btn;
            tick(2);
        end
        bus.btn = 1'b1;
        tick(20);
        chk("bounce_state", 32'(bus.state_out), 32'h2);
        chk("bounce_b", bus.b_out, 32'h3);
        bus.btn = 1'b0;
        tick(20);
        chk("bounce_release_state", 32'(bus.state_out), 32'h2);

        // Opcode press: exec_pulse is high for exactly the cycle after the capture edge.
        bus.sw  = 32'hFFFF_FFF1;
        bus.btn = 1'b1;
        tick(7);
        chk("op_exec_before", 32'(bus.exec_pulse), 32'h0);
        tick(1);
        chk("op_exec_high", 32'(bus.exec_pulse), 32'h1);
        chk("op_op", 32'(bus.op_out), 32'h1);
        chk("op_state", 32'(bus.state_out), 32'h3);
        tick(1);
        chk("op_exec_after", 32'(bus.exec_pulse), 32'h0);
        // Long hold then long release still gives a single advance.
        tick(91);
        bus.btn = 1'b0;
        tick(100);
        chk("hold_state", 32'(bus.state_out), 32'h3);
        chk("hold_a", bus.a_out, 32'h12);
        chk("hold_b", bus.b_out, 32'h3);

        // Fourth press returns to LOAD_A with all captures held.
        press(32'h0000_00FF, pulses);
        chk("show_state", 32'(bus.state_out), 32'h0);
        chk("show_pulses", 32'(pulses), 32'h0);
        chk("show_a", bus.a_out, 32'h12);
        chk("show_b", bus.b_out, 32'h3);
        chk("show_op", 32'(bus.op_out), 32'h1);

        // Reset mid-sequence with the button held through release.
        press(32'h0000_0005, pulses);
        press(32'h0000_0003, pulses);
        chk("mid_a", bus.a_out, 32'h5);
        chk("mid_b", bus.b_out, 32'h3);
        bus.sw  = 32'hA5A5_0001;
        bus.btn = 1'b1;
        rst_n   = 1'b0;
        tick(1);
        chk("midrst_a", bus.a_out, 32'h0);
        chk("midrst_b", bus.b_out, 32'h0);
        chk("midrst_op", 32'(bus.op_out), 32'h0);
        chk("midrst_state", 32'(bus.state_out), 32'h0);
        rst_n = 1'b1;
        tick(7);
        chk("midrst_a_early", bus.a_out, 32'h0);
        tick(1);
        chk("midrst_a_cap", bus.a_out, 32'hA5A5_0001);
        chk("midrst_state_cap", 32'(bus.state_out), 32'h1);
        chk("midrst_b_cap", bus.b_out, 32'h0);
        tick(20);
        bus.btn = 1'b0;
        tick(20);

        // Wrap: eight presses from a fresh reset.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        total_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            press(32'h0000_0010 + 32'(i), pulses);
            total_pulses += pulses;
        end
        chk("wrap_pulses", 32'(total_pulses), 32'h2);
        chk("wrap_state", 32'(bus.state_out), 32'h0);
        chk("wrap_a", bus.a_out, 32'h14);
        chk("wrap_b", bus.b_out, 32'h15);
        chk("wrap_op", 32'(bus.op_out), 32'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
